// File: rtl/line_mem_pkg.sv
// Shared widths and FSM encoding for the line memory.
// Lines are 512 bits packed as sixteen 32-bit words, word 0 in the low bits.
package line_mem_pkg;
    localparam int LINE_BITS   = 512;
    localparam int WORD_BITS   = 32;
    localparam int OFFSET_BITS = 6;
    localparam int ADDR_BITS   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Latency countdown width; a single-cycle latency still needs one bit.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction
endpackage

// File: rtl/line_mem_if.sv
// Requester <-> line memory bus: one address channel shared by reads and write-backs.
// Read data is returned with a level-held ready; there is no back-pressure on writes.
interface line_mem_if;
    import line_mem_pkg::*;

    logic                 mem_addr_valid;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_write_data_valid;
    logic [LINE_BITS-1:0] mem_write_data;
    logic                 mem_read_data_ready;
    logic [LINE_BITS-1:0] mem_read_data;

    modport master (
        output mem_addr_valid, mem_addr, mem_write_data_valid, mem_write_data,
        input  mem_read_data_ready, mem_read_data
    );

    modport slave (
        input  mem_addr_valid, mem_addr, mem_write_data_valid, mem_write_data,
        output mem_read_data_ready, mem_read_data
    );
endinterface

// File: rtl/line_mem_array.sv
// Line storage: DEPTH_LINES x 512, one synchronous write port and one asynchronous read port.
// Contents are never reset; the caller gates the write enable.
module line_mem_array
    import line_mem_pkg::*;
#(
    parameter int DEPTH_LINES = 1024,
    parameter int IDX_BITS    = $clog2(DEPTH_LINES)
) (
    input  logic                 clk_i,
    input  logic                 wr_en_i,
    input  logic [IDX_BITS-1:0]  wr_idx_i,
    input  logic [LINE_BITS-1:0] wr_dat_i,
    input  logic [IDX_BITS-1:0]  rd_idx_i,
    output logic [LINE_BITS-1:0] rd_dat_o
);
    logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_dat_i;
        end
    end

    assign rd_dat_o = mem_q[rd_idx_i];
endmodule

// File: rtl/line_mem.sv
// Line memory: reads return after LATENCY cycles and hold while the request stays; writes commit at once.
// Reads accepted only in IDLE; LINE_MEM_PERF_EN adds rd_cnt/wr_cnt performance counters.
module line_mem
    import line_mem_pkg::*;
#(
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    line_mem_if.slave   bus
`ifdef LINE_MEM_PERF_EN
    ,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
`endif
);
    localparam int IDX_BITS = $clog2(DEPTH_LINES);
    localparam int CNT_BITS = cnt_width(LATENCY);
    localparam int IDX_LSB  = OFFSET_BITS;
    localparam int IDX_MSB  = OFFSET_BITS + IDX_BITS - 1;

    state_e               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [IDX_BITS-1:0]  idx_q, idx_d;
    logic                 rdy_q, rdy_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;

    logic [IDX_BITS-1:0]  req_idx;
    logic [IDX_BITS-1:0]  arr_rd_idx;
    logic [LINE_BITS-1:0] arr_rd_dat;
    logic [LINE_BITS-1:0] fill_dat;
    logic                 wr_req, rd_req, wr_en;
    logic                 unused_addr_bits;

    assign req_idx          = bus.mem_addr[IDX_MSB:IDX_LSB];
    assign unused_addr_bits = ^{bus.mem_addr[ADDR_BITS-1:IDX_MSB+1], bus.mem_addr[IDX_LSB-1:0]};
    assign wr_req           = bus.mem_addr_valid & bus.mem_write_data_valid;
    assign rd_req           = bus.mem_addr_valid & ~bus.mem_write_data_valid;
    assign wr_en            = wr_req & rst_n;

    // With LATENCY=1 the line is captured at the acceptance edge, before idx_q is loaded.
    assign arr_rd_idx = (state_q == IDLE) ? req_idx : idx_q;

    line_mem_array #(
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_BITS    (IDX_BITS)
    ) u_array (
        .clk_i    (clk),
        .wr_en_i  (wr_en),
        .wr_idx_i (req_idx),
        .wr_dat_i (bus.mem_write_data),
        .rd_idx_i (arr_rd_idx),
        .rd_dat_o (arr_rd_dat)
    );

    // A write landing on the same edge we capture must be seen in the response.
    assign fill_dat = (wr_en && (req_idx == arr_rd_idx)) ? bus.mem_write_data : arr_rd_dat;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rdy_d   = 1'b0;
        rdata_d = '0;

        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    idx_d = req_idx;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_BITS'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (!bus.mem_addr_valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (!bus.mem_addr_valid || bus.mem_write_data_valid || (req_idx != idx_q)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (state_d == RESP) begin
            rdy_d   = 1'b1;
            rdata_d = (state_q == RESP) ? rdata_q : fill_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rdy_q   <= rdy_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.mem_read_data_ready = rdy_q;
    assign bus.mem_read_data       = rdata_q;

`ifdef LINE_MEM_PERF_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if ((state_d == RESP) && (state_q != RESP)) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (wr_en) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif
endmodule

// File: tb/tb_line_mem.sv
// Bench for line_mem: directed scenarios plus randomized reads/writes against a line-array model.
module tb_line_mem;
    localparam int DEPTH = 1024;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    line_mem_if bus();

`ifdef LINE_MEM_PERF_EN
    logic [31:0] rd_cnt, wr_cnt;
`endif

    line_mem #(.DEPTH_LINES(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef LINE_MEM_PERF_EN
        ,
        .rd_cnt(rd_cnt),
        .wr_cnt(wr_cnt)
`endif
    );

    // Reference: memory as an associative array of lines; counters of issued operations.
    logic [511:0] mdl [int unsigned];
    int unsigned  exp_rd, exp_wr;
    int           vectors, errors;

    function automatic int unsigned line_of(input logic [31:0] a);
        return (a >> 6) % DEPTH;
    endfunction

    function automatic logic [31:0] addr_of(input int unsigned li);
        logic [31:0] a;
        a = $urandom;
        a = (a & ~(32'(DEPTH - 1) << 6)) | (32'(li) << 6);
        return a;
    endfunction

    function automatic logic [511:0] rand_line();
        logic [511:0] d;
        for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            exp_rd = 0;
            exp_wr = 0;
        end else if (bus.mem_addr_valid && bus.mem_write_data_valid) begin
            mdl[line_of(bus.mem_addr)] = bus.mem_write_data;
            exp_wr++;
        end
        #1;
    endtask

    task automatic drive_rd(input logic [31:0] a);
        bus.mem_addr_valid = 1'b1; bus.mem_write_data_valid = 1'b0;
        bus.mem_addr = a; bus.mem_write_data = '0;
    endtask

    task automatic drive_wr(input logic [31:0] a, input logic [511:0] d);
        bus.mem_addr_valid = 1'b1; bus.mem_write_data_valid = 1'b1;
        bus.mem_addr = a; bus.mem_write_data = d;
    endtask

    task automatic drive_idle();
        bus.mem_addr_valid = 1'b0; bus.mem_write_data_valid = 1'b0;
        bus.mem_addr = '0; bus.mem_write_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (3) tick();
        vectors++;
        if (bus.mem_read_data_ready !== 1'b0) begin
            errors++; $display("FAIL reset_rdy: got %b want 0", bus.mem_read_data_ready);
        end
        vectors++;
        if (bus.mem_read_data !== '0) begin
            errors++; $display("FAIL reset_data: got %h want 0", bus.mem_read_data);
        end
`ifdef LINE_MEM_PERF_EN
        vectors++;
        if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnt: got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        logic [511:0] exp_line;
        logic         exp_rdy;
        exp_line = {16{32'hA5A5_0001}};
        drive_wr(32'h40, exp_line);
        tick();
        drive_rd(32'h40);
        for (int t = 1; t <= LAT + 1; t++) begin
            tick();
            exp_rdy = (t == LAT + 1);
            vectors++;
            if (bus.mem_read_data_ready !== exp_rdy ||
                bus.mem_read_data !== (exp_rdy ? exp_line : 512'd0)) begin
                errors++;
                $display("FAIL write_read edge %0d: got rdy=%b data=%h want rdy=%b", t,
                         bus.mem_read_data_ready, bus.mem_read_data, exp_rdy);
            end
        end
        exp_rd++;
        drive_idle();
        tick();
        vectors++;
        if (bus.mem_read_data_ready !== 1'b0 || bus.mem_read_data !== '0) begin
            errors++; $display("FAIL write_release: got rdy=%b want 0 data 0", bus.mem_read_data_ready);
        end
    endtask

    task automatic test_hold();
        logic [511:0] a_line, b_line;
        a_line = rand_line(); b_line = rand_line();
        drive_wr(32'h1000, a_line); tick();
        drive_wr(32'h2000, b_line); tick();
        drive_rd(32'h1000);
        for (int t = 1; t <= LAT; t++) begin
            tick();
            vectors++;
            if (bus.mem_read_data_ready !== 1'b0) begin
                errors++; $display("FAIL hold_wait edge %0d: got rdy=%b want 0", t, bus.mem_read_data_ready);
            end
        end
        for (int h = 0; h < 4; h++) begin
            tick();
            vectors++;
            if (bus.mem_read_data_ready !== 1'b1 || bus.mem_read_data !== a_line) begin
                errors++; $display("FAIL hold_stable cycle %0d: got rdy=%b data=%h want %h", h,
                                   bus.mem_read_data_ready, bus.mem_read_data, a_line);
            end
        end
        exp_rd++;
        drive_rd(32'h2000);
        tick();
        vectors++;
        if (bus.mem_read_data_ready !== 1'b0 || bus.mem_read_data !== '0) begin
            errors++; $display("FAIL hold_exit: got rdy=%b data=%h want 0", bus.mem_read_data_ready, bus.mem_read_data);
        end
        for (int t = 0; t <= LAT; t++) begin
            tick();
            vectors++;
            if (bus.mem_read_data_ready !== (t == LAT) ||
                bus.mem_read_data !== ((t == LAT) ? b_line : 512'd0)) begin
                errors++; $display("FAIL hold_next edge %0d: got rdy=%b data=%h", t,
                                   bus.mem_read_data_ready, bus.mem_read_data);
            end
        end
        exp_rd++;
        drive_idle(); tick();
    endtask

    task automatic test_abort();
        logic [511:0] l80, lc0;
        l80 = rand_line(); lc0 = ~l80;
        drive_wr(32'h80, l80); tick();
        drive_wr(32'hC0, lc0); tick();
        drive_rd(32'h80);
        tick(); tick();
        drive_idle();
        tick();
        vectors++;
        if (bus.mem_read_data_ready !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got rdy=%b want 0", bus.mem_read_data_ready);
        end
        drive_rd(32'hC0);
        for (int t = 1; t <= LAT + 1; t++) begin
            tick();
            vectors++;
            if (bus.mem_read_data_ready !== (t == LAT + 1) ||
                bus.mem_read_data !== ((t == LAT + 1) ? lc0 : 512'd0)) begin
                errors++; $display("FAIL abort_next edge %0d: got rdy=%b data=%h", t,
                                   bus.mem_read_data_ready, bus.mem_read_data);
            end
        end
        exp_rd++;
        drive_idle(); tick();
    endtask

    task automatic test_raw();
        drive_wr(32'h100, rand_line()); tick();
        for (int t = 0; t <= LAT; t++) begin
            if (t == 2) drive_wr(32'h100, {16{32'hDEAD_BEEF}});
            else        drive_rd(32'h100);
            tick();
            if (t == LAT) begin
                vectors++;
                if (bus.mem_read_data_ready !== 1'b1 || bus.mem_read_data !== {16{32'hDEAD_BEEF}}) begin
                    errors++; $display("FAIL raw_data: got rdy=%b data=%h want DEADBEEF line",
                                       bus.mem_read_data_ready, bus.mem_read_data);
                end
            end
        end
        exp_rd++;
        drive_idle(); tick();
    endtask

    task automatic test_alias_reset();
        logic [511:0] d0;
        d0 = rand_line();
        drive_wr(32'h0001_0000, d0); tick();
        drive_rd(32'h0);
        repeat (LAT + 1) tick();
        exp_rd++;
        vectors++;
        if (bus.mem_read_data_ready !== 1'b1 || bus.mem_read_data !== d0) begin
            errors++; $display("FAIL alias_data: got rdy=%b data=%h want %h",
                               bus.mem_read_data_ready, bus.mem_read_data, d0);
        end
`ifdef LINE_MEM_PERF_EN
        vectors++;
        if (rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
            errors++; $display("FAIL perf_cnt: got rd=%0d wr=%0d want rd=%0d wr=%0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
        end
`endif
        rst_n = 1'b0;
        drive_wr(32'h0, ~d0);
        tick();
        vectors++;
        if (bus.mem_read_data_ready !== 1'b0 || bus.mem_read_data !== '0) begin
            errors++; $display("FAIL resp_reset: got rdy=%b data=%h want 0", bus.mem_read_data_ready, bus.mem_read_data);
        end
`ifdef LINE_MEM_PERF_EN
        vectors++;
        if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
            errors++; $display("FAIL perf_reset: got rd=%0d wr=%0d want 0/0", rd_cnt, wr_cnt);
        end
`endif
        rst_n = 1'b1;
        drive_rd(32'h0);
        repeat (LAT + 1) tick();
        exp_rd++;
        vectors++;
        if (bus.mem_read_data_ready !== 1'b1 || bus.mem_read_data !== d0) begin
            errors++; $display("FAIL reread_after_reset: got rdy=%b data=%h want %h",
                               bus.mem_read_data_ready, bus.mem_read_data, d0);
        end
        drive_idle(); tick();
    endtask

    task automatic test_random();
        int unsigned  lines[$];
        int unsigned  li, pick;
        logic [511:0] held;
        for (int i = 0; i < 8; i++) begin
            li = $urandom_range(DEPTH - 1);
            drive_wr(addr_of(li), rand_line()); tick();
            lines.push_back(li);
        end
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(3) == 0) begin
                li = $urandom_range(DEPTH - 1);
                drive_wr(addr_of(li), rand_line()); tick();
                lines.push_back(li);
                vectors++;
                if (bus.mem_read_data_ready !== 1'b0) begin
                    errors++; $display("FAIL rnd_write_rdy it %0d: got %b want 0", it, bus.mem_read_data_ready);
                end
            end else begin
                li = lines[$urandom_range(lines.size() - 1)];
                drive_rd(addr_of(li)); tick();
                for (int t = 2; t <= LAT + 1; t++) begin
                    if ($urandom_range(2) == 0) begin
                        pick = ($urandom_range(1) == 0) ? li : lines[$urandom_range(lines.size() - 1)];
                        drive_wr(addr_of(pick), rand_line());
                    end else begin
                        drive_rd(addr_of(li));
                    end
                    tick();
                    if (t <= LAT) begin
                        vectors++;
                        if (bus.mem_read_data_ready !== 1'b0 || bus.mem_read_data !== '0) begin
                            errors++; $display("FAIL rnd_busy it %0d edge %0d: got rdy=%b", it, t, bus.mem_read_data_ready);
                        end
                    end
                end
                exp_rd++;
                held = mdl[li];
                vectors++;
                if (bus.mem_read_data_ready !== 1'b1 || bus.mem_read_data !== held) begin
                    errors++; $display("FAIL rnd_data it %0d line %0d: got rdy=%b data=%h want %h", it, li,
                                       bus.mem_read_data_ready, bus.mem_read_data, held);
                end
                for (int h = 0; h < int'($urandom_range(2)); h++) begin
                    drive_rd(addr_of(li)); tick();
                    vectors++;
                    if (bus.mem_read_data_ready !== 1'b1 || bus.mem_read_data !== held) begin
                        errors++; $display("FAIL rnd_hold it %0d: got rdy=%b data=%h", it,
                                           bus.mem_read_data_ready, bus.mem_read_data);
                    end
                end
                case ($urandom_range(2))
                    0: drive_idle();
                    1: drive_rd(addr_of(li ^ 1));
                    default: begin
                        pick = $urandom_range(DEPTH - 1);
                        drive_wr(addr_of(pick), rand_line());
                        lines.push_back(pick);
                    end
                endcase
                tick();
                vectors++;
                if (bus.mem_read_data_ready !== 1'b0 || bus.mem_read_data !== '0) begin
                    errors++; $display("FAIL rnd_exit it %0d: got rdy=%b data=%h", it,
                                       bus.mem_read_data_ready, bus.mem_read_data);
                end
            end
        end
        drive_idle(); tick();
`ifdef LINE_MEM_PERF_EN
        vectors++;
        if (rd_cnt !== exp_rd || wr_cnt !== exp_wr) begin
            errors++; $display("FAIL rnd_perf: got rd=%0d wr=%0d want rd=%0d wr=%0d", rd_cnt, wr_cnt, exp_rd, exp_wr);
        end
`endif
    endtask

    initial begin
        vectors = 0; errors = 0; exp_rd = 0; exp_wr = 0;
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_write();
        test_hold();
        test_abort();
        test_raw();
        test_alias_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/line_mem.md
LINE_MEM -- requirements
Module: line_mem

Interface
REQ-001 Parameter DEPTH_LINES, default 1024: number of 64-byte lines stored (power of two, >=2).
REQ-002 Parameter LATENCY, default 4: cycles from read acceptance to data ready (>=1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 mem_addr_valid  input  1  requester has a request on mem_addr.
REQ-006 mem_addr  input  32  byte address; line index = mem_addr[6+log2(DEPTH_LINES)-1:6], bits [5:0] and bits above the index are ignored.
REQ-007 mem_write_data_valid  input  1  the current request is a line write-back.
REQ-008 mem_write_data  input  512  write line, word 0 in [31:0], word 15 in [511:480].
REQ-009 mem_read_data_ready  output  1  mem_read_data holds the requested line.
REQ-010 mem_read_data  output  512  read line, same word packing as REQ-008.

Function
REQ-011 A write is mem_addr_valid=1 and mem_write_data_valid=1 on a rising edge; it is accepted in every FSM state, committed to the array at that edge, and produces no ready.
REQ-012 mem_write_data_valid=1 with mem_addr_valid=0 is ignored.
REQ-013 A read is mem_addr_valid=1 and mem_write_data_valid=0; it is accepted only in IDLE, and the line index is latched at acceptance.
REQ-014 FSM states: IDLE, BUSY, RESP; a LATENCY-1 down-counter runs in BUSY.
REQ-015 IDLE->BUSY on read acceptance (LATENCY>1); IDLE->RESP directly when LATENCY=1.
REQ-016 Data ready: a read accepted at edge k drives mem_read_data_ready=1 from edge k+LATENCY.
REQ-017 Read data is taken from the array at the edge entering RESP. A write to the same line committed at or before that edge is visible in the returned data.
REQ-018 In RESP, mem_read_data_ready=1 and mem_read_data are held constant while mem_addr_valid=1 and the line index matches the latched one.
REQ-019 RESP->IDLE at the first edge where mem_addr_valid=0, the line index differs, or a write is presented; ready is deasserted from that edge.
REQ-020 Abort: mem_addr_valid=0 on any edge in BUSY returns the FSM to IDLE and produces no response.
REQ-021 A read presented in the same cycle as an abort or RESP exit is not accepted; it is accepted on the following edge from IDLE.
REQ-022 mem_read_data_ready and mem_read_data are registered outputs, with no combinational path from any input.
REQ-023 mem_read_data is 0 whenever mem_read_data_ready=0.

Reset
REQ-024 rst_n=0 at an edge forces: FSM IDLE, counter 0, mem_read_data_ready=0, mem_read_data=0, and performance counters 0.
REQ-025 Reset during BUSY or RESP discards the pending read; the array contents are not reset or altered.
REQ-026 A write presented during reset is not committed.

Configuration
REQ-027 Macro LINE_MEM_PERF_EN defined: adds outputs rd_cnt[31:0] and wr_cnt[31:0]. rd_cnt increments on each entry to RESP; wr_cnt increments on each committed write. Both counters wrap modulo 2^32.
REQ-028 LINE_MEM_PERF_EN undefined: the rd_cnt and wr_cnt ports and their logic are absent; all other behaviour is identical.

Structure
REQ-029 Package line_mem_pkg holds LINE_BITS=512, WORD_BITS=32, OFFSET_BITS=6, and the FSM state typedef (IDLE/BUSY/RESP).
REQ-030 Sub-module line_mem_array holds the storage: DEPTH_LINES x 512, one synchronous write port and one read port, no reset.

Verification
REQ-031 Write: line 0x40 with data {16{32'hA5A5_0001}} at edge 0, then read 0x40 held valid -> ready=1 from edge 1+LATENCY (edge 5 for LATENCY=4), data equal to the written line.
REQ-032 Hold: keep the read of 0x1000 valid 3 cycles after ready -> ready and data stable 3 cycles. Then change mem_addr to 0x2000 -> ready=0 next edge, new read accepted the edge after.
REQ-033 Abort: read 0x80, drop mem_addr_valid at edge 2 of BUSY -> no ready ever; a read of 0xC0 at the next edge returns line 0xC0 after LATENCY.
REQ-034 RAW in flight: read 0x100 accepted at edge 0, write {16{32'hDEAD_BEEF}} to 0x100 at edge 2 -> ready data = DEAD_BEEF line.
REQ-035 Alias and reset: with DEPTH_LINES=1024, a write to 0x0001_0000 followed by a read of 0x0 returns the same line. Reset asserted in RESP -> ready=0 and data=0 next edge, array contents unchanged on a reread. With LINE_MEM_PERF_EN, rd_cnt/wr_cnt match the issued counts and reset to 0.
